instruction_fetch: RTL and testbench

//  Fetch stage feeding Decode: owns fetch PC, issues aligned 64-bit reads on the instruction bus,

---
 rtl/instruction_fetch.sv | 147 ++++++++++++++
 tb/tb_instruction_fetch.sv | 440 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch.sv
// instruction_fetch: owns the fetch PC, reads 64-bit beats, splits them
// into two instructions and queues them in order for Decode.
module instruction_fetch #(
  parameter int          BUS_DATA_WIDTH = 64,
  parameter logic [63:0] RESET_PC       = 64'h0,
  parameter int          FIFO_DEPTH     = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  output logic                        bus_req,
  output logic [63:0]                 bus_addr,
  input  logic                        bus_ack,
  input  logic                        bus_rvalid,
  input  logic [BUS_DATA_WIDTH-1:0]   bus_rdata,
  input  logic                        redirect_valid,
  input  logic [63:0]                 redirect_pc,
  input  logic                        stall,
  output logic                        stage1_valid,
  output logic [BUS_DATA_WIDTH/2-1:0] stage1_instruction_bits,
  output logic [63:0]                 stage1_pc
);

  localparam int IW = BUS_DATA_WIDTH / 2;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    DROP
  } state_t;

  state_t      state;
  logic [63:0] fetch_pc;
  logic        stale;

  logic [IW-1:0] ins_q [FIFO_DEPTH];
  logic [63:0]   pc_q  [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] wr_ptr1;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;

  logic          empty;
  logic          pop;
  logic          push;
  logic          push_two;
  logic          free_ok;
  logic [CW-1:0] push_n;
  logic [IW-1:0] lo_ins;
  logic [IW-1:0] hi_ins;
  logic [IW-1:0] slot0_ins;
  logic [63:0]   slot0_pc;
  logic          unused_bits;

  assign empty    = (count == '0);
  assign free_ok  = (DEPTH_C - count) >= CW'(2);
  assign pop      = !empty && !stall && !redirect_valid;
  assign push     = (state == WAIT) && bus_rvalid && !redirect_valid;
  assign push_two = push && !fetch_pc[2];
  assign push_n   = push ? (push_two ? CW'(2) : CW'(1)) : '0;
  assign wr_ptr1  = wr_ptr + PW'(1);

  assign lo_ins = bus_rdata[IW-1:0];
  assign hi_ins = bus_rdata[BUS_DATA_WIDTH-1:IW];

  // A mid-beat PC (after a redirect) keeps only the upper instruction.
  assign slot0_ins = fetch_pc[2] ? hi_ins : lo_ins;
  assign slot0_pc  = fetch_pc[2] ? bus_addr + 64'd4 : bus_addr;

  assign unused_bits = ^{redirect_pc[1:0], fetch_pc[1:0]};

  assign stage1_valid = !empty;
  assign stage1_instruction_bits = empty ? '0 : ins_q[rd_ptr];
  assign stage1_pc = empty ? '0 : pc_q[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) begin
      ins_q[wr_ptr] <= slot0_ins;
      pc_q[wr_ptr]  <= slot0_pc;
      if (push_two) begin
        ins_q[wr_ptr1] <= hi_ins;
        pc_q[wr_ptr1]  <= bus_addr + 64'd4;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset || redirect_valid) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + push_n[PW-1:0];
      rd_ptr <= rd_ptr + PW'(pop);
      count  <= count + push_n - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      fetch_pc <= RESET_PC;
      stale    <= 1'b0;
      bus_req  <= 1'b0;
      bus_addr <= '0;
    end else begin
      if (redirect_valid)
        fetch_pc <= {redirect_pc[63:2], 2'b00};
      unique case (state)
        IDLE: begin
          if (!redirect_valid && free_ok) begin
            state    <= REQ;
            bus_req  <= 1'b1;
            bus_addr <= {fetch_pc[63:3], 3'b000};
          end
        end
        REQ: begin
          if (bus_ack) begin
            bus_req <= 1'b0;
            state   <= (stale || redirect_valid) ? DROP : WAIT;
          end else if (redirect_valid) begin
            stale <= 1'b1;
          end
        end
        WAIT: begin
          if (redirect_valid) begin
            state <= bus_rvalid ? IDLE : DROP;
          end else if (bus_rvalid) begin
            fetch_pc <= bus_addr + 64'd8;
            state    <= IDLE;
          end
        end
        DROP: begin
          if (bus_rvalid) begin
            stale <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch: bus responder plus scoreboard of expected
// Decode-side entries, driven and sampled on the falling edge.
module tb_instruction_fetch;

  typedef struct packed {
    logic [31:0] ins;
    logic [63:0] pc;
  } ent_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        bus_req;
  logic [63:0] bus_addr;
  logic        bus_ack;
  logic        bus_rvalid;
  logic [63:0] bus_rdata;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        stall;
  logic        stage1_valid;
  logic [31:0] stage1_instruction_bits;
  logic [63:0] stage1_pc;

  always #5 clk = ~clk;

  instruction_fetch #(
    .BUS_DATA_WIDTH(64),
    .RESET_PC(64'h0),
    .FIFO_DEPTH(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus_req(bus_req),
    .bus_addr(bus_addr),
    .bus_ack(bus_ack),
    .bus_rvalid(bus_rvalid),
    .bus_rdata(bus_rdata),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .stall(stall),
    .stage1_valid(stage1_valid),
    .stage1_instruction_bits(stage1_instruction_bits),
    .stage1_pc(stage1_pc)
  );

  int tests_run = 0;
  int fails = 0;

  ent_t        exp_q[$];
  ent_t        pop_log[$];
  logic [63:0] req_log[$];

  logic [63:0] m_pc = 64'h0;
  logic [63:0] pend_addr;
  logic [63:0] req_addr;
  bit          chk_en = 0;
  bit          pending = 0;
  bit          req_seen = 0;
  bit          txn_drop = 0;
  int          rv_cnt = 0;
  int          ack_hold = 0;
  int          hold_cnt = 0;
  int          rv_delay = 1;
  int          q_seen = 0;

  function automatic logic [31:0] ins_at(input logic [63:0] a);
    if (a == 64'h0) return 32'hAAAA_AAAA;
    if (a == 64'h4) return 32'hBBBB_BBBB;
    return a[31:0] ^ 32'h5A5A_0000;
  endfunction

  // One clock: check what the last edge produced, then drive the next.
  task automatic cyc(input bit st, input bit rd,
                     input logic [63:0] rpc, input bit rst);
    ent_t h;
    bit   rv_now;
    rv_now = 0;
    @(negedge clk);
    q_seen = exp_q.size();
    if (chk_en) begin
      tests_run++;
      if (stage1_valid !== (exp_q.size() != 0)) begin
        fails++;
        $display("FAIL valid: got %b want %b", stage1_valid, exp_q.size() != 0);
      end
      tests_run++;
      if (stage1_valid === 1'b0 &&
          (stage1_instruction_bits !== 32'h0 || stage1_pc !== 64'h0)) begin
        fails++;
        $display("FAIL idle_zero: got ins %h pc %h want 0",
                 stage1_instruction_bits, stage1_pc);
      end
    end
    reset = rst;
    stall = st;
    redirect_valid = rd;
    redirect_pc = rpc;
    bus_ack = 1'b0;
    bus_rvalid = 1'b0;
    bus_rdata = '0;
    if (rst) begin
      exp_q.delete();
      m_pc = 64'h0;
      if (pending) txn_drop = 1;
      req_seen = 0;
      hold_cnt = 0;
    end else begin
      if (chk_en && stage1_valid === 1'b1 && !st && !rd) begin
        h = {stage1_instruction_bits, stage1_pc};
        pop_log.push_back(h);
        tests_run++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL pop: got ins %h pc %h want none", h.ins, h.pc);
        end else begin
          if (h !== exp_q[0]) begin
            fails++;
            $display("FAIL pop: got ins %h pc %h want ins %h pc %h",
                     h.ins, h.pc, exp_q[0].ins, exp_q[0].pc);
          end
          void'(exp_q.pop_front());
        end
      end
      if (bus_req === 1'b1) begin
        tests_run++;
        if (!req_seen) begin
          req_seen = 1;
          req_addr = bus_addr;
          req_log.push_back(bus_addr);
          hold_cnt = ack_hold;
          if (bus_addr !== {m_pc[63:3], 3'b000}) begin
            fails++;
            $display("FAIL req_addr: got %h want %h", bus_addr,
                     {m_pc[63:3], 3'b000});
          end
        end else if (bus_addr !== req_addr) begin
          fails++;
          $display("FAIL addr_stable: got %h want %h", bus_addr, req_addr);
        end
      end
      if (rd && (req_seen || pending)) txn_drop = 1;
    end
    if (pending) begin
      rv_cnt--;
      if (rv_cnt <= 0) begin
        rv_now = 1;
        bus_rvalid = 1'b1;
        bus_rdata = {ins_at(pend_addr + 64'd4), ins_at(pend_addr)};
        if (!txn_drop && !rd && !rst) begin
          if (!m_pc[2]) exp_q.push_back({ins_at(pend_addr), pend_addr});
          exp_q.push_back({ins_at(pend_addr + 64'd4), pend_addr + 64'd4});
          m_pc = pend_addr + 64'd8;
        end
        pending = 0;
        txn_drop = 0;
      end
    end
    if (!rst && bus_req === 1'b1 && req_seen && !pending && !rv_now) begin
      if (hold_cnt > 0) begin
        hold_cnt--;
      end else begin
        bus_ack = 1'b1;
        pending = 1;
        pend_addr = bus_addr;
        rv_cnt = rv_delay;
        req_seen = 0;
      end
    end
    if (rd && !rst) begin
      exp_q.delete();
      m_pc = {rpc[63:2], 2'b00};
    end
  endtask

  task automatic do_reset();
    cyc(0, 0, '0, 1);
    cyc(0, 0, '0, 1);
    ack_hold = 0;
    rv_delay = 1;
    pop_log.delete();
    req_log.delete();
  endtask

  task automatic test_reset();
    chk_en = 0;
    cyc(0, 0, '0, 1);
    chk_en = 1;
    cyc(0, 0, '0, 1);
    cyc(0, 0, '0, 0);
    tests_run++;
    if (bus_req !== 1'b0) begin
      fails++; $display("FAIL reset_req: got %b want 0", bus_req);
    end
    tests_run++;
    if (bus_addr !== 64'h0) begin
      fails++; $display("FAIL reset_addr: got %h want 0", bus_addr);
    end
    tests_run++;
    if (stage1_valid !== 1'b0 || stage1_pc !== 64'h0) begin
      fails++;
      $display("FAIL reset_out: got valid %b pc %h want 0 0", stage1_valid, stage1_pc);
    end
    pop_log.delete();
    req_log.delete();
  endtask

  task automatic test_basic();
    int n;
    cyc(0, 0, '0, 0);
    tests_run++;
    if (bus_req !== 1'b1) begin
      fails++; $display("FAIL first_req_latency: got %b want 1", bus_req);
    end
    n = 0;
    while ((pop_log.size() < 2 || req_log.size() < 2) && n < 20) begin
      cyc(0, 0, '0, 0);
      n++;
    end
    tests_run++;
    if (pop_log.size() < 2 || req_log.size() < 2) begin
      fails++;
      $display("FAIL basic_timeout: got %0d pops want 2", pop_log.size());
    end else begin
      tests_run++;
      if (pop_log[0] !== {32'hAAAA_AAAA, 64'h0}) begin
        fails++;
        $display("FAIL basic_first: got %h %h want aaaaaaaa 0", pop_log[0].ins, pop_log[0].pc);
      end
      tests_run++;
      if (pop_log[1] !== {32'hBBBB_BBBB, 64'h4}) begin
        fails++;
        $display("FAIL basic_second: got %h %h want bbbbbbbb 4", pop_log[1].ins, pop_log[1].pc);
      end
      tests_run++;
      if (req_log[1] !== 64'h8) begin
        fails++; $display("FAIL basic_next_addr: got %h want 8", req_log[1]);
      end
    end
  endtask

  task automatic test_stall();
    do_reset();
    for (int i = 0; i < 10; i++) begin
      cyc(1, 0, '0, 0);
      tests_run++;
      if (bus_req === 1'b1 && q_seen > 2) begin
        fails++; $display("FAIL stall_gate: got req with %0d queued want none", q_seen);
      end
      tests_run++;
      if (stage1_valid === 1'b1 && stage1_pc !== 64'h0) begin
        fails++; $display("FAIL stall_head: got pc %h want 0", stage1_pc);
      end
    end
    tests_run++;
    if (req_log.size() != 2 || bus_req !== 1'b0) begin
      fails++;
      $display("FAIL stall_full: got %0d reqs req %b want 2 0", req_log.size(), bus_req);
    end
    for (int i = 0; i < 24; i++) cyc(0, 0, '0, 0);
    tests_run++;
    if (pop_log.size() < 8) begin
      fails++; $display("FAIL stall_drain: got %0d pops want >=8", pop_log.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        tests_run++;
        if (pop_log[i].pc !== 64'(i * 4)) begin
          fails++;
          $display("FAIL stall_order: got pc %h want %h", pop_log[i].pc, 64'(i * 4));
        end
      end
    end
  endtask

  task automatic wait_pending(input string tag, input bit st);
    int n = 0;
    while (!pending && n < 30) begin
      cyc(st, 0, '0, 0);
      n++;
    end
    tests_run++;
    if (!pending) begin
      fails++; $display("FAIL %s_timeout: got no ack want ack", tag);
    end
  endtask

  task automatic wait_first(input string tag, input logic [63:0] want_req,
                            input logic [63:0] want_pc);
    int n = 0;
    while ((pop_log.size() < 1 || req_log.size() < 1) && n < 30) begin
      cyc(0, 0, '0, 0);
      n++;
    end
    tests_run++;
    if (req_log.size() < 1 || req_log[0] !== want_req) begin
      fails++;
      $display("FAIL %s_req: got %0d reqs first %h want %h", tag,
               req_log.size(), req_log.size() ? req_log[0] : 64'hX, want_req);
    end
    tests_run++;
    if (pop_log.size() < 1 || pop_log[0].pc !== want_pc) begin
      fails++;
      $display("FAIL %s_pop: got %0d pops first pc %h want %h", tag,
               pop_log.size(), pop_log.size() ? pop_log[0].pc : 64'hX, want_pc);
    end
  endtask

  task automatic test_redirect_wait();
    do_reset();
    rv_delay = 3;
    wait_pending("rwait", 0);
    cyc(0, 1, 64'h1006, 0);
    pop_log.delete();
    req_log.delete();
    cyc(0, 0, '0, 0);
    tests_run++;
    if (stage1_valid !== 1'b0) begin
      fails++; $display("FAIL rwait_empty: got %b want 0", stage1_valid);
    end
    wait_first("rwait", 64'h1000, 64'h1004);
  endtask

  task automatic test_redirect_req();
    int n = 0;
    do_reset();
    ack_hold = 3;
    while (!req_seen && n < 10) begin
      cyc(0, 0, '0, 0);
      n++;
    end
    cyc(0, 1, 64'h2000, 0);
    ack_hold = 0;
    pop_log.delete();
    req_log.delete();
    n = 0;
    while (!pending && n < 10) begin
      cyc(0, 0, '0, 0);
      tests_run++;
      if (bus_req === 1'b1 && bus_addr !== 64'h0) begin
        fails++; $display("FAIL rreq_hold: got %h want 0", bus_addr);
      end
      n++;
    end
    req_log.delete();
    wait_first("rreq", 64'h2000, 64'h2000);
  endtask

  task automatic test_reset_wait();
    do_reset();
    rv_delay = 2;
    wait_pending("rstwait", 0);
    cyc(0, 0, '0, 1);
    cyc(0, 0, '0, 0);
    tests_run++;
    if (bus_req !== 1'b0 || stage1_valid !== 1'b0) begin
      fails++;
      $display("FAIL rstwait_out: got req %b valid %b want 0 0", bus_req, stage1_valid);
    end
    cyc(0, 0, '0, 0);
    tests_run++;
    if (stage1_valid !== 1'b0) begin
      fails++; $display("FAIL rstwait_late: got %b want 0", stage1_valid);
    end
    pop_log.delete();
    wait_first("rstwait", 64'h0, 64'h0);
  endtask

  task automatic test_redirect_rvalid();
    int n = 0;
    do_reset();
    while (!(pending && rv_cnt == 1 && exp_q.size() != 0) && n < 40) begin
      cyc(1, 0, '0, 0);
      n++;
    end
    tests_run++;
    if (!(pending && exp_q.size() != 0)) begin
      fails++; $display("FAIL rrv_setup: got no beat in flight want one");
    end
    cyc(0, 1, 64'h3000, 0);
    pop_log.delete();
    req_log.delete();
    cyc(0, 0, '0, 0);
    tests_run++;
    if (stage1_valid !== 1'b0) begin
      fails++; $display("FAIL rrv_flush: got %b want 0", stage1_valid);
    end
    wait_first("rrv", 64'h3000, 64'h3000);
  endtask

  task automatic test_wrap();
    int n = 0;
    do_reset();
    cyc(0, 1, 64'hFFFF_FFFF_FFFF_FFF8, 0);
    while (pop_log.size() < 3 && n < 30) begin
      cyc(0, 0, '0, 0);
      n++;
    end
    tests_run++;
    if (pop_log.size() < 3 || pop_log[2].pc !== 64'h0 ||
        pop_log[1].pc !== 64'hFFFF_FFFF_FFFF_FFFC) begin
      fails++;
      $display("FAIL wrap: got %0d pops want pcs fff8 fffc 0", pop_log.size());
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int i = 0; i < 300; i++) begin
      ack_hold = $urandom_range(0, 2);
      rv_delay = $urandom_range(1, 3);
      cyc($urandom_range(0, 3) == 0, $urandom_range(0, 40) == 0,
          {$urandom(), $urandom()}, 0);
    end
    tests_run++;
    if (pop_log.size() < 30) begin
      fails++; $display("FAIL b2b_progress: got %0d pops want >=30", pop_log.size());
    end
  endtask

  initial begin
    reset = 1'b1;
    stall = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    bus_ack = 1'b0;
    bus_rvalid = 1'b0;
    bus_rdata = '0;
    test_reset();
    test_basic();
    test_stall();
    test_redirect_wait();
    test_redirect_req();
    test_reset_wait();
    test_redirect_rvalid();
    test_wrap();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
